register_file_32: RTL and testbench

REGISTER_FILE_32 -- requirements
Module: register_file_32

---
 rtl/register_file_32.sv | 104 ++++++++++
 tb/tb_register_file_32.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_32.sv
// register_file_32: 2**ADDR_W x DATA_W register file, two combinational read
// ports, one synchronous write port, index 0 hardwired to zero.
// Debug output write_count counts committed writes and saturates at 255.
// Optional build macro: REGFILE_BYPASS_EN forwards write_data to a read port
// in the same cycle when its index matches a pending nonzero write.

// One storage register. It clears asynchronously on reset and loads d on a
// clock edge when we is high.
module register_file_32_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Async clear, enabled load
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (we) q <= d;
    end

endmodule

module register_file_32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [7:0]        write_count
);

    localparam int NREG = 1 << ADDR_W;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    wr_req_t                       wr_req;
    logic                          commit;
    logic [NREG-1:0]               we;
    logic [NREG-1:0][DATA_W-1:0]   regs;

    assign wr_req = '{en: reg_write, addr: write_reg, data: write_data};

    // A write to index 0 is a no-op: it neither stores nor counts.
    assign commit = wr_req.en && (wr_req.addr != '0);

    // One-hot write decode; an unknown address matches no register, so it
    // cannot disturb entries it does not name.
    always_comb begin
        we = '0;
        for (int i = 1; i < NREG; i++)
            we[i] = commit && (wr_req.addr == ADDR_W'(i));
    end

    // r0 has no storage
    assign regs[0] = '0;

    genvar g;
    generate
        for (g = 1; g < NREG; g++) begin : g_reg
            register_file_32_cell #(.DATA_W(DATA_W)) u_cell (
                .clk   (clk),
                .reset (reset),
                .we    (we[g]),
                .d     (wr_req.data),
                .q     (regs[g])
            );
        end
    endgenerate

    // Read ports. Storage clears asynchronously, so during reset the plain
    // array read is already zero; only the forwarding path must be gated.
`ifdef REGFILE_BYPASS_EN
    logic byp1, byp2;
    assign byp1 = !reset && commit && (read_reg1 == wr_req.addr);
    assign byp2 = !reset && commit && (read_reg2 == wr_req.addr);
    assign read_data1 = byp1 ? wr_req.data : regs[read_reg1];
    assign read_data2 = byp2 ? wr_req.data : regs[read_reg2];
`else
    assign read_data1 = regs[read_reg1];
    assign read_data2 = regs[read_reg2];
`endif

    // Saturating count of committed writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              write_count <= '0;
        else if (commit && write_count != 8'hFF) write_count <= write_count + 8'd1;
    end

endmodule

// File: tb/tb_register_file_32.sv
// Self-checking bench for register_file_32 (honours REGFILE_BYPASS_EN if set).
module tb_register_file_32;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data1, read_data2;
    logic [7:0]  write_count;

    int tests = 0;
    int fails = 0;

    // reference model: plain array plus counter
    logic [31:0] model [32];
    int          mcount;

    register_file_32 dut (
        .clk         (clk),
        .reset       (reset),
        .read_reg1   (read_reg1),
        .read_reg2   (read_reg2),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .reg_write   (reg_write),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (reset || idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (reg_write && write_reg == idx) return write_data;
`endif
        return model[idx];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        mcount = 0;
    endtask

    // one rising edge; the model commits whatever was pending before it
    task automatic tick();
        logic        c;
        logic [4:0]  a;
        logic [31:0] d;
        c = !reset && reg_write && (write_reg != 5'd0);
        a = write_reg;
        d = write_data;
        @(posedge clk);
        if (c) begin
            model[a] = d;
            if (mcount < 255) mcount++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; reg_write = 1'b0;
        write_reg = '0; write_data = '0; read_reg1 = '0; read_reg2 = '0;
        model_clear();
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(31 - i); #1;
            tests++;
            if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
                fails++;
                $display("FAIL reset_held idx %0d: got %h/%h expected 0", i, read_data1, read_data2);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(i); #1;
            tests++;
            if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
                fails++;
                $display("FAIL reset_released idx %0d: got %h/%h expected 0", i, read_data1, read_data2);
            end
        end
        tests++;
        if (write_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d expected 0", write_count);
        end
    endtask

    task automatic test_basic_write();
        reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEADBEEF; tick();
        write_reg = 5'd9; write_data = 32'h00000005; tick();
        reg_write = 1'b0; read_reg1 = 5'd8; read_reg2 = 5'd9; #1;
        tests++;
        if (read_data1 !== 32'hDEADBEEF || read_data2 !== 32'h00000005) begin
            fails++;
            $display("FAIL basic_write: got %h/%h expected deadbeef/00000005", read_data1, read_data2);
        end
        tests++;
        if (write_count !== 8'd2) begin
            fails++;
            $display("FAIL basic_count: got %0d expected 2", write_count);
        end
    endtask

    task automatic test_r0_write();
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
        read_reg1 = 5'd0; read_reg2 = 5'd0; #1;
        tests++;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
            fails++;
            $display("FAIL r0_pending: got %h/%h expected 0", read_data1, read_data2);
        end
        tick();
        reg_write = 1'b0; #1;
        tests++;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
            fails++;
            $display("FAIL r0_after: got %h/%h expected 0", read_data1, read_data2);
        end
        tests++;
        if (write_count !== 8'd2) begin
            fails++;
            $display("FAIL r0_count: got %0d expected 2", write_count);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] pre;
        reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h11111111; tick();
        write_data = 32'h22222222; read_reg1 = 5'd3; read_reg2 = 5'd3; #1;
`ifdef REGFILE_BYPASS_EN
        pre = 32'h22222222;
`else
        pre = 32'h11111111;
`endif
        tests++;
        if (read_data1 !== pre || read_data2 !== pre) begin
            fails++;
            $display("FAIL same_cycle_before: got %h/%h expected %h", read_data1, read_data2, pre);
        end
        tick();
        reg_write = 1'b0; #1;
        tests++;
        if (read_data1 !== 32'h22222222 || read_data2 !== 32'h22222222) begin
            fails++;
            $display("FAIL same_cycle_after: got %h/%h expected 22222222", read_data1, read_data2);
        end
    endtask

    task automatic test_reset_mid();
        reg_write = 1'b1; write_reg = 5'd4; write_data = 32'hA5A5A5A5; tick();
        write_data = 32'h12345678; read_reg1 = 5'd4; read_reg2 = 5'd8;
        #2 reset = 1'b1; model_clear(); #1;
        tests++;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0 || write_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_immediate: got %h/%h cnt %0d expected 0/0 cnt 0",
                     read_data1, read_data2, write_count);
        end
        tick();
        tests++;
        if (read_data1 !== 32'd0 || write_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_edge: got %h cnt %0d expected 0 cnt 0", read_data1, write_count);
        end
        #2 reset = 1'b0; #1;
        tests++;
        if (read_data1 !== exp_read(5'd4)) begin
            fails++;
            $display("FAIL reset_mid_release: got %h expected %h", read_data1, exp_read(5'd4));
        end
        tick();
        reg_write = 1'b0; #1;
        tests++;
        if (read_data1 !== 32'h12345678 || write_count !== 8'd1) begin
            fails++;
            $display("FAIL reset_mid_first_write: got %h cnt %0d expected 12345678 cnt 1",
                     read_data1, write_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            reg_write  = 1'($urandom_range(0, 1));
            write_reg  = 5'($urandom_range(0, 31));
            write_data = $urandom;
            read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            read_reg2  = ($urandom_range(0, 7) == 0) ? read_reg1 : 5'($urandom_range(0, 31));
            #1;
            tests++;
            if (read_data1 !== exp_read(read_reg1) || read_data2 !== exp_read(read_reg2)) begin
                fails++;
                $display("FAIL random_read n=%0d r%0d/r%0d: got %h/%h expected %h/%h", n,
                         read_reg1, read_reg2, read_data1, read_data2,
                         exp_read(read_reg1), exp_read(read_reg2));
            end
            tick();
            tests++;
            if (write_count !== 8'(mcount)) begin
                fails++;
                $display("FAIL random_count n=%0d: got %0d expected %0d", n, write_count, mcount);
            end
        end
        reg_write = 1'b0;
    endtask

    task automatic test_saturation();
        reg_write = 1'b1; write_reg = 5'd1;
        for (int n = 0; n < 300; n++) begin
            write_data = $urandom;
            tick();
        end
        reg_write = 1'b0; read_reg1 = 5'd1; read_reg2 = 5'd0; #1;
        tests++;
        if (write_count !== 8'd255) begin
            fails++;
            $display("FAIL saturation_count: got %0d expected 255", write_count);
        end
        tests++;
        if (read_data1 !== model[1] || read_data2 !== 32'd0) begin
            fails++;
            $display("FAIL saturation_last: got %h/%h expected %h/0", read_data1, read_data2, model[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_r0_write();
        test_same_cycle();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
